// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte producers. A round-robin
// arbiter picks a requester while idle, captures its byte and launches the
// frame with a one-cycle start pulse. The block then waits for the
// transmitter's done pulse, enforces an inter-frame gap, and aborts a frame
// whose done never arrives.
//
// Ports
//   i_Clock      system clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_req        per-requester request level, held with data until ack
//   i_data       requester k byte at [k*DATA_W +: DATA_W]
//   o_ack        one-hot, one-cycle pulse: byte of requester k captured
//   o_grant      one-hot, high while requester k's frame is in flight
//   o_tx_start   start pulse to the transmitter
//   o_tx_data    byte to the transmitter, stable from start until done
//   i_tx_active  transmitter busy level
//   i_tx_done    transmitter frame-complete pulse
//   o_busy       high whenever the sequencer is not idle
//   o_timeout    one-cycle pulse when a frame is aborted by timeout
//
// State table
//   state       | meaning
//   S_IDLE      | sampling requests; launches a frame on any request
//   S_WAIT_DONE | frame in flight; counting towards the timeout
//   S_GAP       | enforcing inter-frame gap, waiting for tx to go idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CLKS     = 2,
  parameter int TIMEOUT_CLKS = 65535
) (
  input  logic                      i_Clock,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_tx_start,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_active,
  input  logic                      i_tx_done,
  output logic                      o_busy,
  output logic                      o_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + GAP_CLKS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CLKS > 0) ? CNT_W'(GAP_CLKS - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   last_winner_q;
  logic [IDX_W-1:0]   winner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               tx_start_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic               busy_q;
  logic               timeout_q;

  // Round-robin pick: first requester at or above last_winner+1, wrapping.
  logic               win_valid_d;
  logic [IDX_W-1:0]   win_idx_d;
  logic [IDX_W:0]     cand_d;
  logic [IDX_W-1:0]   cand_idx_d;

  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = '0;
    cand_d      = '0;
    cand_idx_d  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_d = {1'b0, last_winner_q} + (IDX_W + 1)'(i);
      if (cand_d >= NREQ_W) begin
        cand_d = cand_d - NREQ_W;
      end
      cand_idx_d = cand_d[IDX_W-1:0];
      if (!win_valid_d && i_req[cand_idx_d]) begin
        win_valid_d = 1'b1;
        win_idx_d   = cand_idx_d;
      end
    end
  end

  // Winner one-hot and byte, built with constant selects only.
  logic [NUM_REQ-1:0] win_onehot_d;
  logic [DATA_W-1:0]  win_data_d;

  always_comb begin
    win_onehot_d = '0;
    win_data_d   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_valid_d && (win_idx_d == IDX_W'(k))) begin
        win_onehot_d[k] = 1'b1;
        win_data_d      = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      last_winner_q <= LAST_IDX;
      winner_q      <= '0;
      cnt_q         <= '0;
      ack_q         <= '0;
      grant_q       <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (win_valid_d) begin
            state_q    <= S_WAIT_DONE;
            busy_q     <= 1'b1;
            ack_q      <= win_onehot_d;
            grant_q    <= win_onehot_d;
            tx_start_q <= 1'b1;
            tx_data_q  <= win_data_d;
            winner_q   <= win_idx_d;
            cnt_q      <= '0;
          end
        end

        S_WAIT_DONE: begin
          // Done takes priority over a timeout landing on the same edge.
          if (i_tx_done || (cnt_q == TO_LAST)) begin
            timeout_q     <= !i_tx_done;
            grant_q       <= '0;
            last_winner_q <= winner_q;
            cnt_q         <= '0;
            if (GAP_CLKS == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_GAP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_GAP: begin
          // Counter saturates at the gap length while tx is still active.
          if ((cnt_q >= GAP_LAST) && !i_tx_active) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q < GAP_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_ack      = ack_q;
  assign o_grant    = grant_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART_TX instance between NUM_REQ byte producers. It accepts a byte from the winning requester and launches the frame with a one-cycle start pulse. It then waits for the transmitter's done pulse, enforces an inter-frame gap, and recovers from a lost done via a timeout. It sits between the requester blocks and UART_TX, in the same i_Clock domain as Baud_rate and power_manager.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, byte width passed to UART_TX i_data
GAP_CLKS, 2, idle i_Clock cycles enforced between frames (0 = no gap)
TIMEOUT_CLKS, 65535, max cycles in WAIT_DONE before abort (>=2)

Ports:
i_Clock  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_req  input  NUM_REQ  per-requester request level; held with data until ack
i_data  input  NUM_REQ*DATA_W  requester k byte at bits [k*DATA_W +: DATA_W]
o_ack  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester k captured
o_grant  output  NUM_REQ  one-hot, high while requester k's frame is in flight
o_tx_start  output  1  to UART_TX i_start, one-cycle pulse
o_tx_data  output  DATA_W  to UART_TX i_data, stable from start until done
i_tx_active  input  1  from UART_TX o_TX_Active
i_tx_done  input  1  from UART_TX o_TX_Done (one-cycle pulse)
o_busy  output  1  high when state != IDLE
o_timeout  output  1  one-cycle pulse when a frame is aborted by timeout

Behaviour:
- All outputs are registered.
- Reset (i_reset=1 at an edge), effective next cycle, from any state:
  - state=IDLE; o_ack=0, o_grant=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_timeout=0.
  - last_winner=NUM_REQ-1, so requester 0 has first priority.
  - Counters cleared.
  - Reset mid-frame simply abandons the frame; UART_TX shares i_reset.
- States: IDLE, WAIT_DONE, GAP.
- IDLE:
  - Edge with |i_req=1: winner w = first set bit searching upward from (last_winner+1) mod NUM_REQ, wrapping.
  - Next cycle: o_ack[w]=1 and o_tx_start=1 (both one cycle), o_grant[w]=1, o_tx_data=i_data slice w, timeout counter=0, state=WAIT_DONE.
  - Request-to-start latency is 1 cycle.
- i_req and i_data are sampled only in IDLE.
  - A requester may drop req, or present its next byte, the cycle after ack.
  - Req changes outside IDLE are ignored.
- WAIT_DONE:
  - Counter increments each cycle.
  - i_tx_done=1 → grant cleared, last_winner=w, state=GAP (or IDLE if GAP_CLKS=0).
  - Else, counter reaching TIMEOUT_CLKS-1 → o_timeout pulse, grant cleared, last_winner=w, state=GAP/IDLE as above.
  - i_tx_done and timeout on the same edge: done wins, no o_timeout.
- GAP:
  - Counter counts GAP_CLKS cycles.
  - Exit to IDLE when count is complete and i_tx_active=0; otherwise stay, with no timeout in GAP.
- i_tx_done outside WAIT_DONE is ignored.
- Fairness: a requester holding i_req continuously cannot be served twice while another requester is waiting.
- Back-to-back frames:
  - Done edge → GAP_CLKS cycles → IDLE → 1 cycle → next start.
  - Start-to-start = frame time + GAP_CLKS + 2 cycles.
- o_tx_data holds its last value when idle.

Test Plan:
- Reset check: i_reset=1 for 2 cycles → all outputs 0 the cycle after the first reset edge; o_busy=0.
- Single byte loopback:
  - Stimulus: i_req=4'b0010, byte1=8'h3F; UART_TX/UART_RX with TICK_PER_BIT=16, Baud_rate brg_reg=8'h1A.
  - Response: o_ack=4'b0010 for 1 cycle, o_tx_start pulse, o_tx_data=8'h3F; RX reports 8'h3F; o_busy returns to 0 GAP_CLKS+1 cycles after done.
- All requests after reset: i_req=4'hF held, bytes 8'hA0..8'hA3 → acks in order 0,1,2,3,0; RX sequence A0,A1,A2,A3,A0.
- Fairness: req0 held permanently, req2 pulses on each of its acks → grants alternate 0,2,0,2; no consecutive grant to 0 while req2 is high.
- Timeout: TIMEOUT_CLKS=100, i_tx_done forced 0, i_req=4'b0101 → o_timeout pulses exactly 100 cycles after o_tx_start; grant moves to requester 2.
- Reset mid-frame: i_reset=1 during WAIT_DONE of requester 3 → all outputs 0 next cycle; with i_req=4'b1001 after release, requester 0 is granted first.
